// File: rtl/sample_seq_if.sv
// sample_seq_if -- control, memory-read and sample-datapath signals of sample_seq.
//   start/len/abort       : run request, byte count and cancel (from controller)
//   busy/done/count       : run status (to controller)
//   mem_rd/mem_addr       : source memory read strobe and address (to memory)
//   mem_rdata             : read data, one cycle after mem_rd (from memory)
//   smp_w/smp_in          : byte write into the sample datapath (to datapath)
//   smp_r/smp_out         : datapath stall and output byte (from datapath)
//   res_valid/res_data    : captured datapath result strobe and byte
// slave is the sequencer side, master is the environment side.
interface sample_seq_if #(
  parameter int ADDR_W = 10
);
  logic              start;
  logic [ADDR_W:0]   len;
  logic              abort;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              smp_w;
  logic [7:0]        smp_in;
  logic              smp_r;
  logic [7:0]        smp_out;
  logic              res_valid;
  logic [7:0]        res_data;
  logic [ADDR_W:0]   count;

  modport slave (
    input  start, len, abort, mem_rdata, smp_r, smp_out,
    output busy, done, mem_rd, mem_addr, smp_w, smp_in, res_valid, res_data, count
  );

  modport master (
    output start, len, abort, mem_rdata, smp_r, smp_out,
    input  busy, done, mem_rd, mem_addr, smp_w, smp_in, res_valid, res_data, count
  );
endinterface

// File: rtl/sample_seq.sv
// sample_seq -- streams min(len, DATA_SIZE) bytes from a source memory into a
// sample datapath, one byte per FETCH/LOAD/ISSUE round, and returns the
// datapath output captured at each issue.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : sample_seq_if.slave (run control, memory read port, datapath port)
//
// state | meaning
// IDLE  | waiting for start; count holds the last run's value
// FETCH | mem_rd pulse with mem_addr = idx
// LOAD  | mem_rdata captured into the holding register
// ISSUE | byte presented on smp_in; issued on the first cycle smp_r is low
// DONE  | one-cycle done pulse, then back to IDLE
module sample_seq #(
  parameter int DATA_SIZE = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic         clk,
  input  logic         rst,
  sample_seq_if.slave  bus
);

  localparam logic [ADDR_W:0] DSZ = (ADDR_W+1)'(DATA_SIZE);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, ISSUE, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   len_q;
  // idx doubles as the issued-byte count: both clear on start and step on issue.
  logic [ADDR_W:0]   idx;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        hold;
  logic [7:0]        res_hold;

  logic [ADDR_W:0]   len_clamp;
  logic [ADDR_W:0]   idx_nxt;
  logic              issue_go;

  assign len_clamp = (bus.len > DSZ) ? DSZ : bus.len;
  assign idx_nxt   = idx + 1'b1;

  // The issue decision has to react to smp_r and abort in the same cycle,
  // so the issue strobes are decoded from the registered state.
  assign issue_go  = (state == ISSUE) && !bus.smp_r && !bus.abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      idx      <= '0;
      addr_q   <= '0;
      hold     <= '0;
      res_hold <= '0;
    end else if (state != IDLE && bus.abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q <= len_clamp;
            idx   <= '0;
            if (len_clamp != '0) begin
              addr_q <= '0;
              state  <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          hold  <= bus.mem_rdata;
          state <= ISSUE;
        end
        ISSUE: begin
          if (!bus.smp_r) begin
            res_hold <= bus.smp_out;
            idx      <= idx_nxt;
            if (idx_nxt == len_q) begin
              state <= DONE;
            end else begin
              // idx_nxt < len_q <= DATA_SIZE, so the address stays in range.
              addr_q <= idx_nxt[ADDR_W-1:0];
              state  <= FETCH;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE) && !bus.abort;
  assign bus.mem_rd    = (state == FETCH) && !bus.abort;
  assign bus.mem_addr  = addr_q;
  assign bus.smp_w     = issue_go;
  assign bus.smp_in    = hold;
  assign bus.res_valid = issue_go;
  assign bus.res_data  = issue_go ? bus.smp_out : res_hold;
  assign bus.count     = idx;

endmodule
